// File: rtl/uart_tx_pkg.sv
// Shared types and width helpers for the uart_tx frame scheduler.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    // Index width, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int pl_bits(input int full_data_size, input int byte_size);
        return full_data_size - 32'sd2 * byte_size;
    endfunction

    function automatic int max_len(input int full_data_size, input int byte_size);
        return pl_bits(full_data_size, byte_size) / byte_size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request found starting at ptr, with wrap.
module rr_arbiter
    import uart_tx_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Scan from ptr upward; the explicit wrap keeps non-power-of-two N_REQ correct.
    always_comb begin
        int  j;
        logic hit;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        hit   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j        = (int'(ptr) + k >= N_REQ) ? (int'(ptr) + k - N_REQ) : (int'(ptr) + k);
            hit      = !any && req[j];
            grant[j] = grant[j] | hit;
            idx      = hit ? ID_W'(j) : idx;
            any      = any | hit;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx frame transmitter among N_REQ requesters.
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int FULL_DATA_SIZE = 40,
    parameter  int BYTE_SIZE      = 8,
    parameter  int TIMEOUT_CYC    = 65535,
    localparam int PL             = pl_bits(FULL_DATA_SIZE, BYTE_SIZE),
    localparam int ID_W           = id_w(N_REQ)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*BYTE_SIZE-1:0] req_opt,
    input  logic [N_REQ*BYTE_SIZE-1:0] req_len,
    input  logic [N_REQ*PL-1:0]       req_payload,
    input  logic [N_REQ-1:0]          req_mask,
    output logic [FULL_DATA_SIZE-1:0] tx_full_data,
    output logic [BYTE_SIZE-1:0]      tx_opt,
    output logic [BYTE_SIZE-1:0]      tx_len,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [ID_W-1:0]           cur_id,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic                      len_err,
    output logic                      timeout
);

    localparam int                   MAX_LEN  = max_len(FULL_DATA_SIZE, BYTE_SIZE);
    localparam int                   CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BYTE_SIZE-1:0] LEN_MIN  = BYTE_SIZE'(1);
    localparam logic [BYTE_SIZE-1:0] LEN_MAX  = BYTE_SIZE'(MAX_LEN);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [ID_W-1:0]      ID_LAST  = ID_W'(N_REQ - 1);

    state_t                 state_r, state_nxt;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   seen_low_r;
    logic [BYTE_SIZE-1:0]   opt_r, len_r;
    logic [PL-1:0]          payload_r;
    logic [ID_W-1:0]        cur_id_r, done_id_r;
    logic                   done_r, len_err_r, timeout_r;

    logic [N_REQ-1:0]       grant_s;
    logic [ID_W-1:0]        win_s;
    logic                   any_s;
    logic [BYTE_SIZE-1:0]   sel_opt_s, sel_len_s;
    logic [PL-1:0]          sel_payload_s;
    logic                   len_ok_s;
    logic                   accept_s, handshake_s, complete_s, expire_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid & req_mask),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (win_s),
        .any   (any_s)
    );

    assign sel_opt_s     = req_opt[win_s*BYTE_SIZE +: BYTE_SIZE];
    assign sel_len_s     = req_len[win_s*BYTE_SIZE +: BYTE_SIZE];
    assign sel_payload_s = req_payload[win_s*PL +: PL];
    assign len_ok_s      = (sel_len_s >= LEN_MIN) && (sel_len_s <= LEN_MAX);

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nxt   = state_r;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        complete_s  = 1'b0;
        expire_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    accept_s  = 1'b1;
                    state_nxt = len_ok_s ? OFFER : IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OFFER: begin
                if (tx_ready) begin
                    handshake_s = 1'b1;
                    state_nxt   = BUSY;
                end else begin
                    state_nxt = OFFER;
                end
            end
            BUSY: begin
                // Completion takes priority over an expiring counter.
                if (seen_low_r && tx_ready) begin
                    complete_s = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, arbitration pointer and event pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            done_r    <= 1'b0;
            done_id_r <= '0;
            len_err_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            done_r    <= complete_s;
            len_err_r <= accept_s && !len_ok_s;
            timeout_r <= expire_s;
            if (accept_s) rr_ptr_r <= (win_s == ID_LAST) ? '0 : win_s + ID_W'(1);
            if (complete_s) done_id_r <= cur_id_r;
        end
    end

    // Latched frame of the accepted requester.
    always_ff @(posedge CLK) begin
        if (RST) begin
            opt_r     <= '0;
            len_r     <= '0;
            payload_r <= '0;
            cur_id_r  <= '0;
        end else if (accept_s) begin
            opt_r     <= sel_opt_s;
            len_r     <= sel_len_s;
            payload_r <= sel_payload_s;
            cur_id_r  <= win_s;
        end
    end

    // In-flight tracking: ready must drop once before a rise counts as completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r      <= '0;
            seen_low_r <= 1'b0;
        end else if (handshake_s) begin
            cnt_r      <= '0;
            seen_low_r <= 1'b0;
        end else if (state_r == BUSY) begin
            if (!tx_ready) seen_low_r <= 1'b1;
            if (cnt_r != CNT_SAT) cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign req_ready    = (state_r == IDLE) ? grant_s : '0;
    assign tx_valid     = (state_r == OFFER);
    assign busy         = (state_r != IDLE);
    assign tx_full_data = {opt_r, len_r, payload_r};
    assign tx_opt       = opt_r;
    assign tx_len       = len_r;
    assign cur_id       = cur_id_r;
    assign done         = done_r;
    assign done_id      = done_id_r;
    assign len_err      = len_err_r;
    assign timeout      = timeout_r;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx frame transmitter among N_REQ requesters.
- Each requester presents opt, len and payload with a valid/ready handshake.
- The block arbitrates, latches the winner, and builds full_data as {opt, len, payload}.
- It drives the transmitter's in_valid/ready handshake, tracks the frame until the transmitter returns to idle, and reports completion, rejected requests and hung frames.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FULL_DATA_SIZE, 40, transmitter full_data width.
- BYTE_SIZE, 8, byte width.
- TIMEOUT_CYC, 65535, maximum cycles a frame may stay in flight before the abort flag is raised.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester frame request
- req_ready  out  N_REQ  one-hot acceptance; requester i is accepted when req_valid[i] && req_ready[i]
- req_opt  in  N_REQ*BYTE_SIZE  flattened opt bytes; requester i occupies slice [i*BYTE_SIZE +: BYTE_SIZE]
- req_len  in  N_REQ*BYTE_SIZE  flattened payload length in bytes
- req_payload  in  N_REQ*PL  flattened payload, PL = FULL_DATA_SIZE-2*BYTE_SIZE, MSB byte sent first
- req_mask  in  N_REQ  1 = requester enabled for arbitration
- tx_full_data  out  FULL_DATA_SIZE  {opt, len, payload} to the transmitter
- tx_opt  out  BYTE_SIZE  latched opt
- tx_len  out  BYTE_SIZE  latched len
- tx_valid  out  1  to transmitter in_valid
- tx_ready  in  1  from transmitter ready (high only while the transmitter is idle)
- busy  out  1  high whenever state != IDLE
- cur_id  out  ID_W  id of the latched requester, ID_W = max(1, clog2(N_REQ))
- done  out  1  one-cycle pulse when a frame completes
- done_id  out  ID_W  id reported with done
- len_err  out  1  one-cycle pulse when a request is rejected for bad len
- timeout  out  1  one-cycle pulse when a frame exceeds TIMEOUT_CYC

Behaviour:
- Reset values (RST sampled at posedge):
  - state = IDLE, rr_ptr = 0.
  - All outputs 0, including the tx_* data registers.
  - Reset mid-frame abandons the frame with no done pulse; the transmitter is reset by the same RST.
- States: IDLE, OFFER, BUSY.
- IDLE, selection:
  - Eligible set = req_valid & req_mask.
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... with wrap modulo N_REQ.
  - req_ready = one-hot(winner) combinationally, only in IDLE and only when the eligible set is non-zero.
  - Every other state drives req_ready = 0.
- IDLE, acceptance of the winner:
  - Latch opt, len, payload and id.
  - rr_ptr <= (winner+1) mod N_REQ.
  - If 1 <= len <= PL/BYTE_SIZE: go to OFFER.
  - Otherwise: pulse len_err with cur_id = winner and stay in IDLE. The request counts as consumed; rr_ptr still advances.
- OFFER:
  - tx_valid = 1; tx_* outputs hold the latched values.
  - On tx_valid && tx_ready: go to BUSY, clear seen_low and the timeout counter.
  - tx_valid is never dropped before the handshake.
- BUSY:
  - tx_valid = 0.
  - seen_low <= 1 on the first cycle tx_ready == 0.
  - Frame complete when seen_low && tx_ready: pulse done with done_id = cur_id, go to IDLE.
  - The counter increments every BUSY cycle. When it reaches TIMEOUT_CYC: pulse timeout, go to IDLE, no done pulse.
  - If completion and timeout occur in the same cycle, completion wins.
- Latency:
  - Request to tx_valid: 1 cycle (accept in IDLE, OFFER on the next cycle).
  - Transmitter returning to idle to done: 1 cycle.
  - Minimum gap between frames: 2 cycles (IDLE, OFFER).
- Simultaneous events:
  - A requester deasserting req_valid after acceptance has no effect.
  - req_mask changes take effect at the next IDLE selection only.
  - A new request arriving while in BUSY waits; nothing is queued beyond the single latched frame.
- Width rules:
  - rr_ptr is ID_W bits; wrap is explicit modulo N_REQ, so non-power-of-two N_REQ works.
  - The timeout counter is clog2(TIMEOUT_CYC+1) bits and saturates.

Decomposition:
- Package uart_tx_pkg holds:
  - state encoding (IDLE/OFFER/BUSY);
  - PL and MAX_LEN = PL/BYTE_SIZE derivations;
  - the ID_W function.
- Sub-module rr_arbiter (req vector, ptr -> one-hot grant + index, purely combinational) is used for the selection; the FSM, latches and counter stay in uart_tx_sched.

Test Plan:
- Single request, requester 0, opt=0xA5, len=3, payload=0x112233:
  - req_ready[0] pulses once; tx_full_data=0xA503112233 with tx_valid the next cycle.
  - After the transmitter idles, done=1 with done_id=0.
- Requesters 1 and 2 valid continuously, rr_ptr=0:
  - Grant order is 1, 2, 1, 2.
  - done_id sequence matches; no grant is given twice in a row while the other is pending.
- len=0 and then len=4, each from requester 3 (PL=24 bits, so MAX_LEN=3):
  - Each gives len_err with cur_id=3; tx_valid never asserts; rr_ptr becomes 0.
- req_mask=4'b1011 with all four requesters valid:
  - Requester 2 is never granted; order is 0, 1, 3, 0.
- tx_ready held low after the handshake with TIMEOUT_CYC=16:
  - timeout pulses 16 cycles after entering BUSY; no done; state returns to IDLE.
- RST asserted during BUSY:
  - Next cycle busy=0, tx_valid=0, all req_ready=0, rr_ptr=0; no done or timeout pulse.
